// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte producers.
// Round-robin grant of one byte at a time. The arbiter issues a start pulse with the
// byte and waits for the transmitter's done pulse. A watchdog aborts the wait if done
// never arrives.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_req        level request per requester, held until granted
//   i_data       flattened bytes, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_tx_done    one-cycle done pulse from the transmitter
//   o_grant      one-hot, one-cycle pulse: the requester's byte was consumed
//   o_tx_signal  one-cycle start pulse to the transmitter
//   o_tx_byte    registered byte, held until the next grant
//   o_owner      index of the last granted requester
//   o_busy       high whenever not idle
//   o_timeout    one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic                          i_tx_done,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_tx_signal,
  output logic [DATA_WIDTH-1:0]         o_tx_byte,
  output logic [$clog2(NUM_REQ)-1:0]    o_owner,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

  state_e                  state_q, state_d;
  logic [OwnerW-1:0]       last_q, last_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    tx_signal_q, tx_signal_d;
  logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic                    timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
  logic                    win_found;
  logic [OwnerW-1:0]       win_idx;
  logic [OwnerW-1:0]       cand;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search last+1, last+2, ... (mod NUM_REQ); the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = OwnerW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    tx_signal_d = 1'b0;
    tx_byte_d   = tx_byte_q;
    owner_d     = owner_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          tx_signal_d      = 1'b1;
          tx_byte_d        = req_bytes[win_idx];
          owner_d          = win_idx;
          last_d           = win_idx;
          cnt_d            = '0;
          state_d          = StWait;
        end
      end
      StWait: begin
        // Done wins over a timeout landing in the same cycle.
        if (i_tx_done) begin
          state_d = StGap;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      // One idle cycle so the transmitter settles before the next start pulse.
      StGap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      last_q      <= OwnerW'(NUM_REQ - 1);
      cnt_q       <= '0;
      grant_q     <= '0;
      tx_signal_q <= 1'b0;
      tx_byte_q   <= '0;
      owner_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      tx_signal_q <= tx_signal_d;
      tx_byte_q   <= tx_byte_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_tx_signal = tx_signal_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_owner     = owner_q;
  assign o_busy      = (state_q != StIdle);
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter. One instance uses the default watchdog and a
// second instance uses a 50-cycle watchdog. The two share clock and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic        done = 1'b0;
  logic [3:0]  grant;
  logic        tx_sig;
  logic [7:0]  tx_byte;
  logic [1:0]  owner;
  logic        busy, tmo;

  logic [3:0]  req_t = '0;
  logic [31:0] data_t = '0;
  logic        done_t = 1'b0;
  logic [3:0]  grant_t;
  logic        tx_sig_t;
  logic [7:0]  tx_byte_t;
  logic [1:0]  owner_t;
  logic        busy_t, tmo_t;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_req      (req),
    .i_data     (data),
    .i_tx_done  (done),
    .o_grant    (grant),
    .o_tx_signal(tx_sig),
    .o_tx_byte  (tx_byte),
    .o_owner    (owner),
    .o_busy     (busy),
    .o_timeout  (tmo)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50)) dut_to (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_req      (req_t),
    .i_data     (data_t),
    .i_tx_done  (done_t),
    .o_grant    (grant_t),
    .o_tx_signal(tx_sig_t),
    .o_tx_byte  (tx_byte_t),
    .o_owner    (owner_t),
    .o_busy     (busy_t),
    .o_timeout  (tmo_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0; done = 1'b0; req_t = '0; done_t = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Ticks until the main instance grants, bounded at 30 cycles (g stays 0 on expiry).
  task automatic wait_grant(output logic [3:0] g, output int cyc);
    g = '0;
    cyc = 0;
    while (g == 4'b0 && cyc < 30) begin
      tick();
      cyc++;
      g = grant;
    end
  endtask

  // Called right after a grant edge: done is sampled on the third edge after the grant.
  task automatic finish_xfer();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({grant, tx_sig, tx_byte, owner, busy, tmo} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b sig=%b byte=%h owner=%0d busy=%b tmo=%b want all 0",
               grant, tx_sig, tx_byte, owner, busy, tmo);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic busy_drop;
    data = 32'h0000_00A5;
    req  = 4'b0001;
    tick();
    total++;
    if (grant !== 4'b0001 || tx_sig !== 1'b1 || tx_byte !== 8'hA5 || owner !== 2'd0 ||
        busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant got grant=%b sig=%b byte=%h owner=%0d busy=%b want 0001 1 a5 0 1",
               grant, tx_sig, tx_byte, owner, busy);
    end
    req = '0;
    tick();
    total++;
    if (grant !== 4'b0 || tx_sig !== 1'b0 || tx_byte !== 8'hA5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_pulse_width got grant=%b sig=%b byte=%h busy=%b want 0000 0 a5 1",
               grant, tx_sig, tx_byte, busy);
    end
    busy_drop = 1'b0;
    repeat (198) begin
      tick();
      if (busy !== 1'b1 || tmo !== 1'b0) busy_drop = 1'b1;
    end
    total++;
    if (busy_drop !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_hold got dropped=%b want 0", busy_drop);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gap_busy got %b want 1", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0 || tmo !== 1'b0 || owner !== 2'd0) begin
      bad++;
      $display("FAIL single_back_idle got busy=%b grant=%b tmo=%b owner=%0d want 0 0000 0 0",
               busy, grant, tmo, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_g;
    logic [7:0] exp_b;
    int cyc;
    apply_reset();
    data = 32'h1312_1110;
    req  = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_grant(g, cyc);
      exp_g = 4'b0001 << (t % 4);
      exp_b = 8'h10 + 8'(t % 4);
      total++;
      if (g !== exp_g || tx_byte !== exp_b) begin
        bad++;
        $display("FAIL rr_order[%0d] got grant=%b byte=%h want %b %h", t, g, tx_byte, exp_g, exp_b);
      end
      if (t > 0) begin
        total++;
        if (3 + cyc !== 5) begin
          bad++;
          $display("FAIL rr_spacing[%0d] got %0d cycles want 5", t, 3 + cyc);
        end
      end
      finish_xfer();
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_pointer();
    logic [3:0] g;
    int cyc;
    apply_reset();
    data = 32'h4433_2211;
    req  = 4'b0010;
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b0010) begin
      bad++;
      $display("FAIL ptr_first got %b want 0010", g);
    end
    req = 4'b1010;
    finish_xfer();
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b1000 || tx_byte !== 8'h44 || owner !== 2'd3) begin
      bad++;
      $display("FAIL ptr_second got grant=%b byte=%h owner=%0d want 1000 44 3", g, tx_byte, owner);
    end
    req = 4'b0011;
    finish_xfer();
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b0001 || tx_byte !== 8'h11) begin
      bad++;
      $display("FAIL ptr_third got grant=%b byte=%h want 0001 11", g, tx_byte);
    end
    req = 4'b0010;
    finish_xfer();
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b0010 || tx_byte !== 8'h22 || owner !== 2'd1) begin
      bad++;
      $display("FAIL ptr_fourth got grant=%b byte=%h owner=%0d want 0010 22 1", g, tx_byte, owner);
    end
    req = '0;
    finish_xfer();
    tick();
  endtask

  task automatic test_timeout();
    int first;
    int npulse;
    logic early;
    data_t = 32'h0000_3C5A;
    req_t  = 4'b0001;
    tick();
    total++;
    if (grant_t !== 4'b0001 || tx_byte_t !== 8'h5A) begin
      bad++;
      $display("FAIL to_grant got grant=%b byte=%h want 0001 5a", grant_t, tx_byte_t);
    end
    req_t = '0;
    first = -1;
    npulse = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (tmo_t === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (first !== 50 || npulse !== 1 || busy_t !== 1'b0) begin
      bad++;
      $display("FAIL to_abort got first=%0d pulses=%0d busy=%b want 50 1 0", first, npulse, busy_t);
    end
    req_t = 4'b0010;
    tick();
    total++;
    if (grant_t !== 4'b0010 || tx_byte_t !== 8'h3C || owner_t !== 2'd1) begin
      bad++;
      $display("FAIL to_regrant got grant=%b byte=%h owner=%0d want 0010 3c 1",
               grant_t, tx_byte_t, owner_t);
    end
    req_t = '0;
    early = 1'b0;
    repeat (49) begin
      tick();
      if (tmo_t !== 1'b0 || busy_t !== 1'b1) early = 1'b1;
    end
    done_t = 1'b1;
    tick();
    done_t = 1'b0;
    total++;
    if (early !== 1'b0 || tmo_t !== 1'b0 || busy_t !== 1'b1) begin
      bad++;
      $display("FAIL to_done_last got early=%b tmo=%b busy=%b want 0 0 1", early, tmo_t, busy_t);
    end
    tick();
    total++;
    if (busy_t !== 1'b0 || tmo_t !== 1'b0) begin
      bad++;
      $display("FAIL to_done_idle got busy=%b tmo=%b want 0 0", busy_t, tmo_t);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    int cyc;
    apply_reset();
    data = 32'h0000_7700;
    req  = 4'b0010;
    tick();
    req = '0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({grant, tx_sig, tx_byte, owner, busy, tmo} !== 16'h0) begin
      bad++;
      $display("FAIL async_reset got grant=%b sig=%b byte=%h owner=%0d busy=%b tmo=%b want all 0",
               grant, tx_sig, tx_byte, owner, busy, tmo);
    end
    tick();
    rst_n = 1'b1;
    data = 32'h00CC_00AA;
    req  = 4'b0101;
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b0001 || owner !== 2'd0 || tx_byte !== 8'hAA) begin
      bad++;
      $display("FAIL async_ptr_reset got grant=%b owner=%0d byte=%h want 0001 0 aa", g, owner, tx_byte);
    end
    req = 4'b0100;
    finish_xfer();
    wait_grant(g, cyc);
    total++;
    if (g !== 4'b0100 || owner !== 2'd2 || tx_byte !== 8'hCC) begin
      bad++;
      $display("FAIL async_req2 got grant=%b owner=%0d byte=%h want 0100 2 cc", g, owner, tx_byte);
    end
    req = '0;
    finish_xfer();
    tick();
  endtask

  task automatic test_done_ignored();
    logic [3:0] g;
    logic stray;
    int cyc;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (busy !== 1'b0 || grant !== 4'b0 || tmo !== 1'b0) begin
      bad++;
      $display("FAIL idle_done got busy=%b grant=%b tmo=%b want 0 0000 0", busy, grant, tmo);
    end
    data = 32'h0000_0099;
    req  = 4'b0001;
    wait_grant(g, cyc);
    req = 4'b0100;
    tick();
    req = '0;
    done = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0 || tmo !== 1'b0) begin
      bad++;
      $display("FAIL gap_done got busy=%b grant=%b tmo=%b want 0 0000 0", busy, grant, tmo);
    end
    done = 1'b0;
    stray = 1'b0;
    repeat (5) begin
      tick();
      if (grant !== 4'b0 || busy !== 1'b0) stray = 1'b1;
    end
    total++;
    if (g !== 4'b0001 || stray !== 1'b0) begin
      bad++;
      $display("FAIL dropped_req got first=%b stray=%b want 0001 0", g, stray);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_timeout();
    test_async_reset();
    test_done_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
